// File: rtl/display_pkg.sv
// Shared constants for the lock's seven-segment display path.
package display_pkg;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_U     = 4'hA;
  localparam logic [3:0] CODE_B     = 4'hB;
  localparam logic [3:0] CODE_C     = 4'hC;
  localparam logic [3:0] CODE_L     = 4'hD;
  localparam logic [3:0] CODE_N     = 4'hF;
  localparam logic [3:0] CODE_ZERO  = 4'h0;

  localparam int DEFAULT_NDIGITS      = 8;
  localparam int DEFAULT_PRESCALE     = 100000;
  localparam int DEFAULT_FLASH_FRAMES = 64;

endpackage

// File: rtl/display_scan_if.sv
// Frame-load handshake and display drive lines between the lock logic and the scanner.
interface display_scan_if
  import display_pkg::*;
#(
  parameter int NDIGITS = DEFAULT_NDIGITS
);

  logic                   load;
  logic [4*NDIGITS-1:0]   digits_in;
  logic [NDIGITS-1:0]     enables_in;
  logic [NDIGITS-1:0]     points_in;
  logic [NDIGITS-1:0]     flash_in;
  logic                   load_ack;
  logic [3:0]             digit_code;
  logic [NDIGITS-1:0]     anode_n;
  logic                   dp_n;
  logic                   frame_tick;

  modport master (
    output load, digits_in, enables_in, points_in, flash_in,
    input  load_ack, digit_code, anode_n, dp_n, frame_tick
  );

  modport slave (
    input  load, digits_in, enables_in, points_in, flash_in,
    output load_ack, digit_code, anode_n, dp_n, frame_tick
  );

endinterface

// File: rtl/tick_gen.sv
// Modulo-N counter advancing on en_i; tc_o flags the enabled cycle that wraps it.
module tick_gen #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic         at_top_s;

  assign at_top_s = (count_q == W'(N - 1));
  assign tc_o     = en_i && at_top_s;
  assign count_o  = count_q;

  // Count 0..N-1 while enabled, wrapping at the top.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (en_i) begin
      if (at_top_s) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end else begin
      count_q <= count_q;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Eight-digit common-anode scanner: one digit per slot, guard cycle per slot,
// per-digit blank/flash, and a shadow frame swapped in only at frame end.
module display_scan
  import display_pkg::*;
#(
  parameter int NDIGITS      = DEFAULT_NDIGITS,
  parameter int PRESCALE     = DEFAULT_PRESCALE,
  parameter int FLASH_FRAMES = DEFAULT_FLASH_FRAMES
) (
  input  logic           clock,
  input  logic           reset_n,
  display_scan_if.slave  bus
);

  localparam int SW = $clog2(NDIGITS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [PW-1:0] pre_count_s;
  logic [FW-1:0] flash_count_unused_s;
  logic          slot_end_s;
  logic          frame_end_s;
  logic          flash_tc_s;
  logic          transfer_s;
  logic          shown_s;

  logic [SW-1:0]          slot_q,      slot_d;
  logic [4*NDIGITS-1:0]   disp_code_q, disp_code_d;
  logic [NDIGITS-1:0]     disp_en_q,   disp_en_d;
  logic [NDIGITS-1:0]     disp_pt_q,   disp_pt_d;
  logic [NDIGITS-1:0]     disp_fl_q,   disp_fl_d;
  logic [4*NDIGITS-1:0]   sh_code_q,   sh_code_d;
  logic [NDIGITS-1:0]     sh_en_q,     sh_en_d;
  logic [NDIGITS-1:0]     sh_pt_q,     sh_pt_d;
  logic [NDIGITS-1:0]     sh_fl_q,     sh_fl_d;
  logic                   pending_q,   pending_d;
  logic                   phase_q,     phase_d;
  logic [NDIGITS-1:0]     anode_q,     anode_d;
  logic [3:0]             code_q,      code_d;
  logic                   dp_q,        dp_d;
  logic                   ack_q,       ack_d;
  logic                   tick_q,      tick_d;

  tick_gen #(.N(PRESCALE), .W(PW)) u_prescale (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .en_i    (1'b1),
    .count_o (pre_count_s),
    .tc_o    (slot_end_s)
  );

  tick_gen #(.N(FLASH_FRAMES), .W(FW)) u_flash (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .en_i    (frame_end_s),
    .count_o (flash_count_unused_s),
    .tc_o    (flash_tc_s)
  );

  assign frame_end_s = slot_end_s && (slot_q == SW'(NDIGITS - 1));
  assign transfer_s  = frame_end_s && pending_q;

  // Next-state for slot, frame buffers, flash phase and the registered outputs.
  always_comb begin
    slot_d      = slot_q;
    disp_code_d = disp_code_q;
    disp_en_d   = disp_en_q;
    disp_pt_d   = disp_pt_q;
    disp_fl_d   = disp_fl_q;
    sh_code_d   = sh_code_q;
    sh_en_d     = sh_en_q;
    sh_pt_d     = sh_pt_q;
    sh_fl_d     = sh_fl_q;
    pending_d   = pending_q;
    phase_d     = phase_q;

    if (slot_end_s) begin
      slot_d = (slot_q == SW'(NDIGITS - 1)) ? '0 : slot_q + 1'b1;
    end else begin
      slot_d = slot_q;
    end

    if (flash_tc_s) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end

    // Transfer reads the old shadow; a same-cycle load only refills the shadow.
    if (transfer_s) begin
      disp_code_d = sh_code_q;
      disp_en_d   = sh_en_q;
      disp_pt_d   = sh_pt_q;
      disp_fl_d   = sh_fl_q;
      pending_d   = 1'b0;
    end else begin
      pending_d   = pending_q;
    end

    if (bus.load) begin
      sh_code_d = bus.digits_in;
      sh_en_d   = bus.enables_in;
      sh_pt_d   = bus.points_in;
      sh_fl_d   = bus.flash_in;
      pending_d = 1'b1;
    end else begin
      sh_code_d = sh_code_q;
    end

    shown_s = disp_en_q[slot_q] && !(disp_fl_q[slot_q] && !phase_q);
    if (shown_s) begin
      code_d = disp_code_q[{slot_q, 2'b00} +: 4];
      dp_d   = ~disp_pt_q[slot_q];
      if (pre_count_s == PW'(0)) begin
        anode_d = '1;
      end else begin
        anode_d = ~({{(NDIGITS-1){1'b0}}, 1'b1} << slot_q);
      end
    end else begin
      code_d  = CODE_BLANK;
      dp_d    = 1'b1;
      anode_d = '1;
    end

    ack_d  = transfer_s;
    tick_d = frame_end_s;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      disp_code_q <= {NDIGITS{CODE_BLANK}};
      disp_en_q   <= '0;
      disp_pt_q   <= '0;
      disp_fl_q   <= '0;
      sh_code_q   <= '0;
      sh_en_q     <= '0;
      sh_pt_q     <= '0;
      sh_fl_q     <= '0;
      pending_q   <= 1'b0;
      phase_q     <= 1'b1;
      anode_q     <= '1;
      code_q      <= CODE_BLANK;
      dp_q        <= 1'b1;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      disp_code_q <= disp_code_d;
      disp_en_q   <= disp_en_d;
      disp_pt_q   <= disp_pt_d;
      disp_fl_q   <= disp_fl_d;
      sh_code_q   <= sh_code_d;
      sh_en_q     <= sh_en_d;
      sh_pt_q     <= sh_pt_d;
      sh_fl_q     <= sh_fl_d;
      pending_q   <= pending_d;
      phase_q     <= phase_d;
      anode_q     <= anode_d;
      code_q      <= code_d;
      dp_q        <= dp_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.anode_n    = anode_q;
  assign bus.digit_code = code_q;
  assign bus.dp_n       = dp_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed + randomized bench for display_scan, checked cycle by cycle against
// a cycle-number arithmetic model of the scan schedule and frame handshake.
module tb_display_scan;

  localparam int ND    = 8;
  localparam int P     = 4;
  localparam int FF    = 2;
  localparam int FRAME = ND * P;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  display_scan_if #(.NDIGITS(ND)) bus ();

  display_scan #(.NDIGITS(ND), .PRESCALE(P), .FLASH_FRAMES(FF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n      = 0;
  int acks   = 0;

  logic [31:0] m_dig, s_dig;
  logic [7:0]  m_en, m_pt, m_fl, s_en, s_pt, s_fl;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_dig  = {8{4'hE}};
    m_en   = 8'h00;
    m_pt   = 8'h00;
    m_fl   = 8'h00;
    s_dig  = 32'h0;
    s_en   = 8'h00;
    s_pt   = 8'h00;
    s_fl   = 8'h00;
    m_pend = 1'b0;
  endtask

  // One clock: predict outputs from cycle number n, clock, update model, compare.
  task automatic step();
    int          cnt, slot;
    bit          fe, on, shown, eack, ldv;
    logic [7:0]  ea;
    logic [3:0]  ec;
    logic        ed;
    cnt   = n % P;
    slot  = (n / P) % ND;
    fe    = (n % FRAME) == FRAME - 1;
    on    = ((n / FRAME) / FF) % 2 == 0;
    shown = m_en[slot] && !(m_fl[slot] && !on);
    ec    = shown ? m_dig[slot*4 +: 4] : 4'hE;
    ed    = shown ? ~m_pt[slot] : 1'b1;
    ea    = (shown && cnt != 0) ? ~(8'h01 << slot) : 8'hFF;
    eack  = fe && m_pend;
    ldv   = bus.load;
    @(posedge clock);
    if (eack) begin
      m_dig  = s_dig; m_en = s_en; m_pt = s_pt; m_fl = s_fl;
      m_pend = 1'b0;
    end
    if (ldv) begin
      s_dig  = bus.digits_in; s_en = bus.enables_in;
      s_pt   = bus.points_in; s_fl = bus.flash_in;
      m_pend = 1'b1;
    end
    n++;
    #1;
    check("anode_n",    {24'h0, bus.anode_n},    {24'h0, ea});
    check("digit_code", {28'h0, bus.digit_code}, {28'h0, ec});
    check("dp_n",       {31'h0, bus.dp_n},       {31'h0, ed});
    check("load_ack",   {31'h0, bus.load_ack},   {31'h0, eack});
    check("frame_tick", {31'h0, bus.frame_tick}, {31'h0, fe});
    if (bus.load_ack) acks++;
    bus.load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic load_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                            input logic [7:0] f);
    bus.load       = 1'b1;
    bus.digits_in  = d;
    bus.enables_in = e;
    bus.points_in  = p;
    bus.flash_in   = f;
    step();
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_anode"}, {24'h0, bus.anode_n},    32'h0000_00FF);
    check({tag, "_code"},  {28'h0, bus.digit_code}, 32'h0000_000E);
    check({tag, "_dp"},    {31'h0, bus.dp_n},       32'h1);
    check({tag, "_ack"},   {31'h0, bus.load_ack},   32'h0);
    check({tag, "_tick"},  {31'h0, bus.frame_tick}, 32'h0);
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.digits_in  = 32'h0;
    bus.enables_in = 8'h00;
    bus.points_in  = 8'h00;
    bus.flash_in   = 8'h00;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check_reset_outputs("reset");

    run(40);
    check("idle_acks", acks, 0);

    acks = 0;
    load_frame(32'hFDCB_A0E0, 8'hFF, 8'h01, 8'h00);
    align(0);
    check("first_ack", acks, 1);
    run(2 * FRAME);
    check("ack_once", acks, 1);

    load_frame(32'hFDCB_A0E0, 8'b1111_0111, 8'h01, 8'h00);
    run(2 * FRAME);

    load_frame(32'hFDCB_A0E0, 8'hFF, 8'h01, 8'h01);
    run(6 * FRAME);

    align(2);
    acks = 0;
    load_frame(32'h1234_5678, 8'hFF, 8'h0F, 8'h00);
    run(3);
    load_frame(32'h8765_4321, 8'hFF, 8'hF0, 8'h00);
    run(2 * FRAME);
    check("double_load_acks", acks, 1);

    align(FRAME - 1);
    acks = 0;
    load_frame(32'hCAFE_0123, 8'h7E, 8'h81, 8'h00);
    check("edge_load_no_ack", acks, 0);
    run(FRAME);
    check("edge_load_late_ack", acks, 1);

    align(0);
    load_frame(32'h0F0F_0F0F, 8'hFF, 8'hFF, 8'h00);
    for (int i = 0; i < FRAME && !((n / P) % ND == 5 && n % P == 2); i++) step();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    acks = 0;
    run(2 * FRAME);
    check("post_reset_acks", acks, 0);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        bus.load       = 1'b1;
        bus.digits_in  = $urandom;
        bus.enables_in = 8'($urandom);
        bus.points_in  = 8'($urandom);
        bus.flash_in   = 8'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
